// File: rtl/latch_exerciser.sv
// rtl/latch_exerciser.sv - stimulus/response engine for an external level-sensitive D latch
//
// Purpose:
//   Steps an external D latch through a fixed 10-vector (En,D) sequence, holds
//   each vector for HOLD_CYCLES clocks, and compares the latch's synchronized
//   Q/not_Q against an internal behavioural latch model SETTLE_CYCLES into
//   each step. Failing steps are counted (saturating) and a pass flag is
//   raised when a run ends with no failures.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle run request, ignored while busy
//   q_in       in   latch Q, asynchronous to clk
//   not_q_in   in   latch not_Q, asynchronous to clk
//   en_out     out  registered En drive to the latch
//   d_out      out  registered D drive to the latch
//   busy       out  run in progress
//   done       out  run finished, held until next accepted start or reset
//   pass       out  done with zero failing steps
//   err_count  out  failing step count, saturating at all-ones
//   step       out  current vector index 0..9

module latch_exerciser #(
  parameter int HOLD_CYCLES   = 50,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q_in,
  input  logic             not_q_in,
  output logic             en_out,
  output logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       step
);

  localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CMP   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       LAST_STEP = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  // Vector table, returned as {en, d}.
  function automatic logic [1:0] vec_rom(input logic [3:0] idx);
    logic [1:0] v;
    case (idx)
      4'd0:    v = 2'b00;
      4'd1:    v = 2'b10;
      4'd2:    v = 2'b11;
      4'd3:    v = 2'b10;
      4'd4:    v = 2'b00;
      4'd5:    v = 2'b01;
      4'd6:    v = 2'b11;
      4'd7:    v = 2'b01;
      4'd8:    v = 2'b00;
      4'd9:    v = 2'b01;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic               dv_q, dv_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [3:0]         step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               model_q_q, model_q_d;
  logic               model_valid_q, model_valid_d;

  // Two-flop synchronizers for the asynchronous latch outputs.
  logic               q_meta_q, q_sync_q;
  logic               nq_meta_q, nq_sync_q;

  // Step-entry strobe and the vector being applied on that edge.
  logic               load_vec;
  logic [1:0]         vec;
  logic               step_fail;
  logic [3:0]         step_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta_q  <= 1'b0;
      q_sync_q  <= 1'b0;
      nq_meta_q <= 1'b0;
      nq_sync_q <= 1'b0;
    end else begin
      q_meta_q  <= q_in;
      q_sync_q  <= q_meta_q;
      nq_meta_q <= not_q_in;
      nq_sync_q <= nq_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      en_q          <= 1'b0;
      dv_q          <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= '0;
      step_q        <= 4'd0;
      cnt_q         <= '0;
      model_q_q     <= 1'b0;
      model_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      dv_q          <= dv_d;
      done_q        <= done_d;
      err_q         <= err_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      model_q_q     <= model_q_d;
      model_valid_q <= model_valid_d;
    end
  end

  // Non-complementary outputs fail as well as a wrong Q.
  assign step_fail = (q_sync_q != model_q_q) || (nq_sync_q != ~model_q_q);
  assign step_inc  = step_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    dv_d          = dv_q;
    done_d        = done_q;
    err_d         = err_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    model_q_d     = model_q_q;
    model_valid_d = model_valid_q;
    load_vec      = 1'b0;
    vec           = 2'b00;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE lasts one cycle but already behaves like IDLE.
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (start) begin
          state_d       = S_DRIVE;
          done_d        = 1'b0;
          err_d         = '0;
          step_d        = 4'd0;
          cnt_d         = '0;
          // Each run starts with an unknown latch state.
          model_q_d     = 1'b0;
          model_valid_d = 1'b0;
          load_vec      = 1'b1;
          vec           = vec_rom(4'd0);
        end
      end

      S_DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Single compare cycle per step gives at most one increment.
        if ((cnt_q == CNT_CMP) && model_valid_q && step_fail && (err_q != '1)) begin
          err_d = err_q + ERR_W'(1);
        end
        if (cnt_q == CNT_LAST) begin
          if (step_q < LAST_STEP) begin
            step_d   = step_inc;
            cnt_d    = '0;
            load_vec = 1'b1;
            vec      = vec_rom(step_inc);
          end else begin
            state_d = S_DONE;
            en_d    = 1'b0;
            dv_d    = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Drive the new vector and advance the model on the same edge.
    if (load_vec) begin
      en_d = vec[1];
      dv_d = vec[0];
      if (vec[1]) begin
        model_q_d     = vec[0];
        model_valid_d = 1'b1;
      end
    end
  end

  assign en_out    = en_q;
  assign d_out     = dv_q;
  assign busy      = (state_q == S_DRIVE);
  assign done      = done_q;
  assign pass      = done_q && (err_q == '0);
  assign err_count = err_q;
  assign step      = step_q;

endmodule

// File: tb/tb_latch_exerciser.sv
// tb/tb_latch_exerciser.sv - self-checking bench for latch_exerciser against a run-time model
//
// Purpose:
//   Two exercisers (ERR_W=4 and ERR_W=3) each drive their own latch, whose
//   outputs pass through a selectable fault. A run-time model predicts every
//   output from the elapsed cycles since the accepted start.
//
// Ports: none.

module tb_latch_exerciser;

  localparam int H = 50;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   fault_mode = 0;

  logic       en_a, d_a, busy_a, done_a, pass_a, q_a, nq_a, lat_a;
  logic [3:0] err_a, step_a;
  logic       en_b, d_b, busy_b, done_b, pass_b, q_b, nq_b, lat_b;
  logic [2:0] err_b;
  logic [3:0] step_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  latch_exerciser #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S), .ERR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_a), .not_q_in(nq_a),
    .en_out(en_a), .d_out(d_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .step(step_a)
  );

  latch_exerciser #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S), .ERR_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_b), .not_q_in(nq_b),
    .en_out(en_b), .d_out(d_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .step(step_b)
  );

  // Ideal latches under test.
  always_latch if (en_a) lat_a <= d_a;
  always_latch if (en_b) lat_b <= d_b;

  // 0 ideal, 1 stuck Q=0/notQ=1, 2 notQ tied to Q, 3 outputs swapped.
  function automatic logic [1:0] fault_out(input int m, input logic l);
    case (m)
      1:       return 2'b01;
      2:       return {l, l};
      3:       return {~l, l};
      default: return {l, ~l};
    endcase
  endfunction

  assign {q_a, nq_a} = fault_out(fault_mode, lat_a);
  assign {q_b, nq_b} = fault_out(fault_mode, lat_b);

  // Reference tables straight from the vector list and expected-Q list.
  int rom_en[10] = '{0, 1, 1, 1, 0, 0, 1, 0, 0, 0};
  int rom_d[10]  = '{0, 0, 1, 0, 0, 1, 1, 1, 0, 1};
  int exp_q[10]  = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 1};

  function automatic bit step_fails(input int m, input int s);
    if (s == 0) return 1'b0;
    case (m)
      0:       return 1'b0;
      1:       return exp_q[s] == 1;
      default: return 1'b1;
    endcase
  endfunction

  // Failures registered by elapsed cycle tt of a run.
  function automatic int fails_by(input int m, input int tt);
    int n = 0;
    for (int s = 1; s < 10; s++) begin
      if ((s * H + S <= tt) && step_fails(m, s)) n++;
    end
    return n;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Run-time model: elapsed cycles since the accepted start.
  bit m_active = 0, m_done = 0, m_ran = 0;
  int m_t = 0, m_fault = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_done <= 0; m_ran <= 0; m_t <= 0;
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (m_t + 1 == 10 * H) begin
        m_active <= 0;
        m_done   <= 1;
      end
    end else if (start) begin
      m_active <= 1; m_done <= 0; m_ran <= 1; m_t <= 0; m_fault <= fault_mode;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int e_step, e_en, e_d, e_cnt, tt;
    e_step = m_active ? m_t / H : (m_ran ? 9 : 0);
    e_en   = m_active ? rom_en[m_t / H] : 0;
    e_d    = m_active ? rom_d[m_t / H] : 0;
    tt     = m_active ? m_t : 10 * H;
    e_cnt  = m_ran ? fails_by(m_fault, tt) : 0;
    chk("busy_a", busy_a, m_active);
    chk("done_a", done_a, m_done);
    chk("en_a", en_a, e_en);
    chk("d_a", d_a, e_d);
    chk("step_a", step_a, e_step);
    chk("err_a", err_a, imin(e_cnt, 15));
    chk("pass_a", pass_a, m_done && e_cnt == 0);
    chk("busy_b", busy_b, m_active);
    chk("step_b", step_b, e_step);
    chk("err_b", err_b, imin(e_cnt, 7));
    chk("pass_b", pass_b, m_done && e_cnt == 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy_a, 0);
    chk({nm, "_done"}, done_a, 0);
    chk({nm, "_en"}, en_a, 0);
    chk({nm, "_d"}, d_a, 0);
    chk({nm, "_step"}, step_a, 0);
    chk({nm, "_err"}, err_a, 0);
    chk({nm, "_pass"}, pass_a, 0);
  endtask

  // sa: edge index (since accept) at which start is re-pulsed; ra: reset edge.
  task automatic do_run(input int m, input int ea, input int eb, input int sa, input int ra);
    int n;
    fault_mode = m;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (!done_a && n < 600) begin
      start = (n + 1 == sa);
      tick;
      n++;
      if (n == ra) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("midrun_reset");
        tick;
        rst_n = 1'b1;
        tick;
        return;
      end
    end
    start = 1'b0;
    chk("latency", n, 10 * H);
    chk("final_err_a", err_a, ea);
    chk("final_err_b", err_b, eb);
    chk("final_pass_a", pass_a, ea == 0);
    chk("final_pass_b", pass_b, eb == 0);
    tick;
    chk("idle_after_run", busy_a, 0);
    chk("done_held", done_a, 1);
  endtask

  initial begin
    tick; tick; tick;
    chk_zero("reset");
    rst_n = 1'b1;
    tick;

    do_run(0, 0, 0, -1, -1);
    do_run(1, 5, 5, -1, -1);
    do_run(2, 9, 7, -1, -1);
    do_run(3, 9, 7, -1, -1);
    do_run(0, 0, 0, 4 * H + 7, -1);
    do_run(2, 9, 7, 10 * H, -1);
    do_run(2, 0, 0, -1, 6 * H + 10);
    do_run(0, 0, 0, -1, -1);

    for (int i = 0; i < 5000; i++) begin
      if (!m_active && ($urandom % 8 == 0)) fault_mode = $urandom % 4;
      start = ($urandom % 30 == 0);
      if ($urandom % 1500 == 0) rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
    end
    start = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
